gray_to_binary_pipe: RTL and testbench
======================================

Name: gray_to_binary_pipe

Overview:
- Receive-side counterpart of the team's binary-to-Gray encoder: converts a stream of Gray-coded words back to binary.
- Two-stage valid/ready pipeline with backpressure.
- Checks the single-bit-change property between successive accepted words and flags violations alongside the decoded word.
- Sits after a Gray-coded counter, pointer or encoder link, feeding binary consumers.

Parameters:
- WIDTH, 4, bit width of the Gray input and binary output (min 2).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous reset, active low, sampled on rising clk.
- in_valid  input  1  gray_in holds a valid word.
- in_ready  output  1  block can accept a word this cycle.
- gray_in  input  WIDTH  Gray-coded input word.
- out_valid  output  1  binary_out/step_err/dir_up valid.
- out_ready  input  1  downstream accepts the output word this cycle.
- binary_out  output  WIDTH  decoded binary word.
- step_err  output  1  accepted word violated the one-bit-change rule.
- dir_up  output  1  count direction (see Optional Feature); 0 when feature absent.

Behaviour:
- Reset (rst_n=0 at edge):
  - v1, v2, out_valid, binary_out, step_err, dir_up, prev_gray and first_seen all go to 0.
  - In-flight words are discarded.
  - in_ready is combinational and reads 1 whenever v1=0, so it is 1 from the first cycle after reset.
- Transfer rules:
  - Input transfer = in_valid && in_ready.
  - Output transfer = out_valid && out_ready.
- Stall rules:
  - adv2 = !v2 || out_ready.
  - adv1 = !v1 || adv2.
  - in_ready = adv1, combinational from out_ready and valid flags only; no dependence on in_valid.
- Stage 1, on input transfer:
  - Register gray_in into g1.
  - Compute d = popcount(gray_in ^ prev_gray).
  - err1 = first_seen && (d != 1). Distance 0 (repeat) and distance >1 (jump) both flag.
  - Update prev_gray <= gray_in and first_seen <= 1.
  - The first word after reset never flags.
- Stage 2, when adv2 && v1:
  - binary_out[WIDTH-1] = g1[WIDTH-1].
  - binary_out[i] = binary_out[i+1] ^ g1[i], MSB-to-LSB prefix XOR.
  - step_err <= err1; v2 <= 1.
  - When adv2 && !v1: v2 <= 0.
- Latency: 2 cycles from input transfer to out_valid with no stall. Throughput is 1 word/cycle while out_ready=1.
- Backpressure:
  - With out_ready=0, both stages fill, then in_ready drops.
  - No word is lost, duplicated or reordered.
  - Outputs hold stable while out_valid && !out_ready.
- Simultaneous input and output transfer on a full pipe: both stages shift in the same cycle.
- Wrap-around: Gray 1000 -> 0000 (WIDTH=4) is a legal 1-bit step; no flag.
- prev_gray tracks accepted words only; stalled or invalid cycles do not update it.
- Reset mid-operation overrides every handshake; no partial words are emitted afterwards.

Optional Feature:
- Macro: G2B_DIR_EN.
- Defined:
  - Stage 2 keeps prev_bin, the binary of the last word emitted from stage 2; reset 0, first-word flag shared with first_seen semantics.
  - dir_up = 1 when binary_out == prev_bin + 1 mod 2^WIDTH, else 0.
  - dir_up is registered with binary_out and is 0 for the first word after reset.
- Not defined: dir_up tied to 0, no extra registers.

Decomposition:
- Package gray_pkg:
  - default width constant GRAY_W=4;
  - function gray2bin(logic [WIDTH-1:0]);
  - function popcount for the step check.
- One natural sub-module: gray_to_bin_comb, a pure combinational prefix-XOR decoder instantiated in stage 2. It is reusable by other receive paths.

Test Plan (WIDTH=4):
- Reset: hold rst_n=0 for 3 cycles, then release -> out_valid=0, binary_out=0000, step_err=0, in_ready=1 on the first cycle after release.
- Full sequence: feed the 16 Gray codes 0000,0001,0011,0010,0110,…,1000, back-to-back, out_ready=1 -> binary_out 0..15 in order, each 2 cycles after input, step_err=0 throughout; wrap 1000->0000 gives binary 0000 with step_err=0.
- Violations:
  - 0000 then 0011 -> second output binary_out=0010, step_err=1.
  - Then repeat 0011 -> binary_out=0010, step_err=1.
  - Then 0010 -> binary_out=0011, step_err=0.
- Backpressure: stream continuously, drop out_ready for 4 cycles -> in_ready=0 once both stages are full. Outputs stay frozen. On release, the word sequence resumes with no gaps or duplicates, checked against a scoreboard.
- Mid-stream reset: assert rst_n=0 with both stages full -> out_valid=0 next cycle. The first word after reset (0101) outputs binary 0110 with step_err=0.
- G2B_DIR_EN defined:
  - Gray 0001 -> 0011 gives dir_up=1 on the second output.
  - 0011 -> 0001 gives dir_up=0.
  - Macro undefined -> dir_up always 0.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared Gray-code helpers for receive-side decode paths.
// Functions work on GRAY_MAXW-wide words; callers zero-extend narrower operands.
package gray_pkg;

  localparam int GRAY_W    = 4;
  localparam int GRAY_MAXW = 64;

  // Zero-extended high bits leave the lower prefix-XOR untouched.
  function automatic logic [GRAY_MAXW-1:0] gray2bin(input logic [GRAY_MAXW-1:0] g);
    logic [GRAY_MAXW-1:0] b;
    b[GRAY_MAXW-1] = g[GRAY_MAXW-1];
    for (int i = GRAY_MAXW-2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic int popcount(input logic [GRAY_MAXW-1:0] v);
    int cnt;
    cnt = 0;
    for (int i = 0; i < GRAY_MAXW; i++) cnt += int'(v[i]);
    return cnt;
  endfunction

endpackage

// File: rtl/gray_to_bin_comb.sv
// Pure combinational Gray-to-binary decoder: each binary bit is the XOR of
// all Gray bits at and above it.
module gray_to_bin_comb #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign bin[i] = ^gray[WIDTH-1:i];
  end

endmodule

// File: rtl/gray_to_binary_pipe.sv
// Two-stage valid/ready Gray-to-binary decoder with one-bit-step checking.
// Optional macro G2B_DIR_EN adds a registered count-up indicator on dir_up.
module gray_to_binary_pipe
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] gray_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] binary_out,
  output logic             step_err,
  output logic             dir_up
);

  localparam int STAGES = 2;

  logic [STAGES:1]  vld_pipe;
  logic             adv1, adv2, in_fire, step_bad;
  logic [WIDTH-1:0] g1, prev_gray, dec;
  logic             err1, first_seen;

  assign adv2      = !vld_pipe[2] || out_ready;
  assign adv1      = !vld_pipe[1] || adv2;
  assign in_ready  = adv1;
  assign in_fire   = in_valid && adv1;
  assign out_valid = vld_pipe[2];
  assign step_bad  = popcount(GRAY_MAXW'(gray_in ^ prev_gray)) != 1;

  gray_to_bin_comb #(.WIDTH(WIDTH)) u_dec (
    .gray (g1),
    .bin  (dec)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe   <= '0;
      g1         <= '0;
      err1       <= 1'b0;
      prev_gray  <= '0;
      first_seen <= 1'b0;
      binary_out <= '0;
      step_err   <= 1'b0;
    end else begin
      // Stage 1: capture and step-check; history follows accepted words only.
      if (adv1) vld_pipe[1] <= in_valid;
      if (in_fire) begin
        g1         <= gray_in;
        err1       <= first_seen && step_bad;
        prev_gray  <= gray_in;
        first_seen <= 1'b1;
      end
      // Stage 2: decode; holds while downstream stalls.
      if (adv2) begin
        vld_pipe[2] <= vld_pipe[1];
        if (vld_pipe[1]) begin
          binary_out <= dec;
          step_err   <= err1;
        end
      end
    end
  end

`ifdef G2B_DIR_EN
  logic [WIDTH-1:0] prev_bin;
  logic             bin_seen;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_bin <= '0;
      bin_seen <= 1'b0;
      dir_up   <= 1'b0;
    end else if (adv2 && vld_pipe[1]) begin
      dir_up   <= bin_seen && (dec == prev_bin + WIDTH'(1));
      prev_bin <= dec;
      bin_seen <= 1'b1;
    end
  end
`else
  assign dir_up = 1'b0;
`endif

endmodule

// File: tb/tb_gray_to_binary_pipe.sv
// Directed bench for gray_to_binary_pipe (WIDTH=4): vector table plus
// hand-written backpressure, mid-stream reset and direction sequences.
module tb_gray_to_binary_pipe;

  logic       clk = 1'b0;
  logic       rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [3:0] gray_in, binary_out;
  logic       step_err, dir_up;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gray_to_binary_pipe #(.WIDTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .gray_in    (gray_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .binary_out (binary_out),
    .step_err   (step_err),
    .dir_up     (dir_up)
  );

  typedef struct {
    logic [3:0] g;
    logic [3:0] b;
    logic       e;
  } vec_t;

  vec_t tbl[20];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] sb[$];
    logic [3:0] frozen;
    logic [3:0] exp_b;
    int         idx, got;
    logic       exp_dir[3];

    tbl[0]  = '{4'b0000, 4'd0,  1'b0};
    tbl[1]  = '{4'b0001, 4'd1,  1'b0};
    tbl[2]  = '{4'b0011, 4'd2,  1'b0};
    tbl[3]  = '{4'b0010, 4'd3,  1'b0};
    tbl[4]  = '{4'b0110, 4'd4,  1'b0};
    tbl[5]  = '{4'b0111, 4'd5,  1'b0};
    tbl[6]  = '{4'b0101, 4'd6,  1'b0};
    tbl[7]  = '{4'b0100, 4'd7,  1'b0};
    tbl[8]  = '{4'b1100, 4'd8,  1'b0};
    tbl[9]  = '{4'b1101, 4'd9,  1'b0};
    tbl[10] = '{4'b1111, 4'd10, 1'b0};
    tbl[11] = '{4'b1110, 4'd11, 1'b0};
    tbl[12] = '{4'b1010, 4'd12, 1'b0};
    tbl[13] = '{4'b1011, 4'd13, 1'b0};
    tbl[14] = '{4'b1001, 4'd14, 1'b0};
    tbl[15] = '{4'b1000, 4'd15, 1'b0};
    tbl[16] = '{4'b0000, 4'd0,  1'b0};  // wrap 1000 -> 0000
    tbl[17] = '{4'b0011, 4'd2,  1'b1};  // two-bit jump
    tbl[18] = '{4'b0011, 4'd2,  1'b1};  // repeat
    tbl[19] = '{4'b0010, 4'd3,  1'b0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; gray_in = '0;
    #1;
    do_reset(3);
    #1;
    chk("rst out_valid",  32'(out_valid),  32'd0);
    chk("rst binary_out", 32'(binary_out), 32'd0);
    chk("rst step_err",   32'(step_err),   32'd0);
    chk("rst dir_up",     32'(dir_up),     32'd0);
    chk("rst in_ready",   32'(in_ready),   32'd1);

    // Back-to-back stream: entry i-1 must appear exactly after tick i.
    for (int i = 0; i <= 20; i++) begin
      in_valid = (i < 20);
      gray_in  = (i < 20) ? tbl[i].g : 4'b0000;
      tick();
      if (i == 0) chk("latency out_valid", 32'(out_valid), 32'd0);
      else begin
        chk($sformatf("vec%0d valid", i-1), 32'(out_valid),  32'd1);
        chk($sformatf("vec%0d bin",   i-1), 32'(binary_out), 32'(tbl[i-1].b));
        chk($sformatf("vec%0d err",   i-1), 32'(step_err),   32'(tbl[i-1].e));
      end
    end
    in_valid = 1'b0;
    tick();
    chk("drain out_valid", 32'(out_valid), 32'd0);

    // Backpressure: stream 12 words, out_ready low on cycles 4..7.
    do_reset(1);
    idx = 0; got = 0;
    for (int c = 0; c < 40 && got < 12; c++) begin
      out_ready = !(c >= 4 && c <= 7);
      in_valid  = (idx < 12);
      gray_in   = 4'(idx ^ (idx >> 1));
      #1;
      if (c >= 4 && c <= 7) chk($sformatf("bp in_ready c%0d", c), 32'(in_ready), 32'd0);
      if (c == 4) frozen = binary_out;
      if (c >= 5 && c <= 7) begin
        chk($sformatf("bp hold valid c%0d", c), 32'(out_valid), 32'd1);
        chk($sformatf("bp hold bin c%0d", c), 32'(binary_out), 32'(frozen));
      end
      if (out_valid && out_ready) begin
        exp_b = (sb.size() > 0) ? sb.pop_front() : 4'hx;
        chk($sformatf("bp word%0d", got), 32'(binary_out), 32'(exp_b));
        chk($sformatf("bp err%0d", got), 32'(step_err), 32'd0);
        got++;
      end
      if (in_valid && in_ready) begin
        sb.push_back(4'(idx));
        idx++;
      end
      tick();
    end
    chk("bp words received", 32'(got), 32'd12);
    in_valid = 1'b0; out_ready = 1'b1;

    // Mid-stream reset with both stages full.
    do_reset(1);
    out_ready = 1'b0; in_valid = 1'b1;
    gray_in = 4'b0001; tick();
    gray_in = 4'b0011; tick();
    gray_in = 4'b0010; tick();
    chk("mr full out_valid", 32'(out_valid), 32'd1);
    chk("mr full in_ready",  32'(in_ready),  32'd0);
    rst_n = 1'b0; tick();
    chk("mr rst out_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b1; out_ready = 1'b1;
    gray_in = 4'b0101; tick();
    in_valid = 1'b0; tick();
    chk("mr first valid", 32'(out_valid),  32'd1);
    chk("mr first bin",   32'(binary_out), 32'd6);
    chk("mr first err",   32'(step_err),   32'd0);
    tick();
    chk("mr no extra", 32'(out_valid), 32'd0);

    // Direction: binary 1, 2, 1.
`ifdef G2B_DIR_EN
    exp_dir = '{1'b0, 1'b1, 1'b0};
`else
    exp_dir = '{1'b0, 1'b0, 1'b0};
`endif
    do_reset(1);
    in_valid = 1'b1;
    gray_in = 4'b0001; tick();
    gray_in = 4'b0011; tick();
    chk("dir w0 bin", 32'(binary_out), 32'd1);
    chk("dir w0 dir", 32'(dir_up), 32'(exp_dir[0]));
    gray_in = 4'b0001; tick();
    chk("dir w1 bin", 32'(binary_out), 32'd2);
    chk("dir w1 dir", 32'(dir_up), 32'(exp_dir[1]));
    in_valid = 1'b0; tick();
    chk("dir w2 bin", 32'(binary_out), 32'd1);
    chk("dir w2 err", 32'(step_err), 32'd0);
    chk("dir w2 dir", 32'(dir_up), 32'(exp_dir[2]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
